// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) types and constants for the receive path (deserializer and decoder).
package hamming_pkg;

    localparam int HAM_CW_WIDTH   = 7;
    localparam int HAM_DATA_WIDTH = 4;

    typedef logic [HAM_CW_WIDTH-1:0]   ham_cw_t;
    typedef logic [HAM_DATA_WIDTH-1:0] ham_data_t;

    typedef enum logic {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } deser_state_t;

endpackage

// File: rtl/hamming_cw_holdreg.sv
// Single-entry valid/ready holding register for assembled codewords.
// A load that arrives while the entry is full and not draining is reported as a drop.
module hamming_cw_holdreg #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] data,
    input  logic         ready,
    output logic [W-1:0] code_out,
    output logic         code_valid,
    output logic         drop
);

    assign drop = load && code_valid && !ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            code_out   <= '0;
            code_valid <= 1'b0;
        end else if (load && (!code_valid || ready)) begin
            code_out   <= data;
            code_valid <= 1'b1;
        end else if (code_valid && ready) begin
            code_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/hamming_cw_deser.sv
// Serial-to-parallel codeword collector feeding the Hamming(7,4) decoder.
// Build option HAMMING_DESER_STATS_EN adds the delivered/dropped codeword counters.
//
// state | meaning
// HUNT  | waiting for the first sof; plain bits are ignored
// SHIFT | collecting bits; a full codeword goes to the holding register
module hamming_cw_deser
    import hamming_pkg::*;
#(
    parameter int CW_WIDTH    = HAM_CW_WIDTH,
    parameter bit MSB_FIRST   = 1'b1,
    parameter bit REQUIRE_SOF = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bit_in,
    input  logic                bit_valid,
    input  logic                sof,
    input  logic                clr_ovf,
    output logic [CW_WIDTH-1:0] code_out,
    output logic                code_valid,
    input  logic                code_ready,
    output logic                overflow,
    output logic [15:0]         cw_count,
    output logic [15:0]         drop_count
);

    localparam int                CNT_W     = $clog2(CW_WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(CW_WIDTH);
    localparam deser_state_t      RST_STATE = REQUIRE_SOF ? HUNT : SHIFT;

    deser_state_t        state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [CW_WIDTH-1:0] shreg, shreg_nxt, shifted;
    logic                accept, complete, drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_STATE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            shreg <= shreg_nxt;
        end
    end

    // Older bits of a discarded partial codeword shift out before completion, so no clear is needed on sof.
    always_comb begin
        if (MSB_FIRST) shifted = {shreg[CW_WIDTH-2:0], bit_in};
        else           shifted = {bit_in, shreg[CW_WIDTH-1:1]};
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        complete  = 1'b0;
        accept    = bit_valid && (sof || state == SHIFT);
        if (accept) begin
            state_nxt = SHIFT;
            shreg_nxt = shifted;
            cnt_nxt   = sof ? CNT_W'(1) : cnt + CNT_W'(1);
            if (cnt_nxt == CNT_FULL) begin
                complete = 1'b1;
                cnt_nxt  = '0;
            end
        end
    end

    hamming_cw_holdreg #(.W(CW_WIDTH)) u_holdreg (
        .clk        (clk),
        .rst        (rst),
        .load       (complete),
        .data       (shifted),
        .ready      (code_ready),
        .code_out   (code_out),
        .code_valid (code_valid),
        .drop       (drop)
    );

    // A drop in the same cycle as clr_ovf must leave the flag set.
    always_ff @(posedge clk) begin
        if (rst)          overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (clr_ovf) overflow <= 1'b0;
    end

`ifdef HAMMING_DESER_STATS_EN
    logic transfer;
    assign transfer = code_valid && code_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cw_count   <= '0;
            drop_count <= '0;
        end else begin
            if (transfer) cw_count   <= cw_count + 16'd1;
            if (drop)     drop_count <= drop_count + 16'd1;
        end
    end
`else
    assign cw_count   = '0;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_hamming_cw_deser.sv
// Scoreboard bench for hamming_cw_deser: stimulus pushes expected codewords, a negedge monitor pops on each transfer.
module tb_hamming_cw_deser;

`ifdef HAMMING_DESER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bit_in = 1'b0, bit_valid = 1'b0, sof = 1'b0, clr_ovf = 1'b0;
    logic        code_ready = 1'b0;
    logic [6:0]  code_out;
    logic        code_valid, overflow;
    logic [15:0] cw_count, drop_count;

    int checks = 0;
    int errors = 0;
    logic [6:0] exp_q[$];

    always #5 clk = ~clk;

    hamming_cw_deser dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .sof        (sof),
        .clr_ovf    (clr_ovf),
        .code_out   (code_out),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .overflow   (overflow),
        .cw_count   (cw_count),
        .drop_count (drop_count)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every transfer must match the oldest expected codeword.
    always @(negedge clk) begin
        if (!rst && code_valid && code_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_cw: got %b expected none", code_out);
            end else begin
                logic [6:0] e;
                e = exp_q.pop_front();
                if (code_out !== e) begin
                    errors++;
                    $display("FAIL cw_data: got %b expected %b", code_out, e);
                end
            end
        end
    end

    // Inputs change 1 time unit after the rising edge; each call consumes one edge.
    task automatic send_bit(input logic b, input logic s, input logic c);
        bit_in    = b;
        bit_valid = 1'b1;
        sof       = s;
        clr_ovf   = c;
        @(posedge clk); #1;
        sof       = 1'b0;
        clr_ovf   = 1'b0;
    endtask

    task automatic send_cw(input logic [6:0] cw, input logic with_sof);
        for (int i = 0; i < 7; i++) send_bit(cw[6-i], with_sof && (i == 0), 1'b0);
    endtask

    task automatic idle(input int n);
        bit_valid = 1'b0;
        sof       = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bit_valid = 1'b0;
        sof = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic chk_reset_state();
        chk("rst_valid", 16'(code_valid), 16'd0);
        chk("rst_code",  16'(code_out),   16'd0);
        chk("rst_ovf",   16'(overflow),   16'd0);
        chk("rst_cwcnt", cw_count,        16'd0);
        chk("rst_drcnt", drop_count,      16'd0);
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();
        chk_reset_state();

        // Bits before the first sof are ignored.
        code_ready = 1'b1;
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        exp_q.push_back(7'b1100110);
        send_cw(7'b1100110, 1'b1);
        idle(3);
        chk("hunt_cwcnt", cw_count, STATS ? 16'd1 : 16'd0);

        // Latency: valid and data right after the 7th bit's edge.
        exp_q.push_back(7'b1010101);
        send_cw(7'b1010101, 1'b1);
        chk("lat_valid", 16'(code_valid), 16'd1);
        chk("lat_code",  16'(code_out),   16'h55);
        idle(2);
        chk("lat_drain", 16'(code_valid), 16'd0);
        chk("t1_cwcnt",  cw_count, STATS ? 16'd2 : 16'd0);

        // Partial codeword overridden by sof.
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        exp_q.push_back(7'b0110011);
        send_cw(7'b0110011, 1'b1);
        idle(2);
        chk("partial_ovf",   16'(overflow), 16'd0);
        chk("partial_cwcnt", cw_count, STATS ? 16'd3 : 16'd0);

        // Back-to-back codewords, second without sof.
        exp_q.push_back(7'b1011010);
        exp_q.push_back(7'b0100101);
        send_cw(7'b1011010, 1'b1);
        send_cw(7'b0100101, 1'b0);
        chk("b2b_valid", 16'(code_valid), 16'd1);
        chk("b2b_code",  16'(code_out),   16'h25);
        idle(2);
        chk("b2b_cwcnt", cw_count, STATS ? 16'd5 : 16'd0);

        // Overflow under backpressure: second codeword dropped.
        code_ready = 1'b0;
        exp_q.push_back(7'b0000001);
        send_cw(7'b0000001, 1'b1);
        send_cw(7'b1111111, 1'b0);
        chk("ovf_set",   16'(overflow),   16'd1);
        chk("ovf_hold",  16'(code_out),   16'h01);
        chk("ovf_drcnt", drop_count, STATS ? 16'd1 : 16'd0);
        idle(3);
        chk("stall_valid", 16'(code_valid), 16'd1);
        chk("stall_code",  16'(code_out),   16'h01);
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        chk("ovf_clr", 16'(overflow), 16'd0);
        code_ready = 1'b1;
        idle(2);

        // Drop and clr_ovf in the same cycle: set wins.
        code_ready = 1'b0;
        exp_q.push_back(7'b1110000);
        send_cw(7'b1110000, 1'b1);
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b1);
        chk("ovf_setwins", 16'(overflow), 16'd1);
        chk("setwins_hold", 16'(code_out), 16'h70);
        chk("setwins_drcnt", drop_count, STATS ? 16'd2 : 16'd0);
        code_ready = 1'b1;
        idle(2);
        chk("pre_rst_cwcnt", cw_count, STATS ? 16'd7 : 16'd0);

        // Reset mid-codeword with a held codeword and overflow pending.
        code_ready = 1'b0;
        send_cw(7'b0011100, 1'b1);
        send_cw(7'b1111111, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0);
        do_reset();
        chk_reset_state();
        code_ready = 1'b1;
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        exp_q.push_back(7'b0101101);
        send_cw(7'b0101101, 1'b1);
        idle(3);
        chk("post_rst_cwcnt", cw_count, STATS ? 16'd1 : 16'd0);
        chk("queue_empty", 16'(exp_q.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/hamming_cw_deser.md
Name: hamming_cw_deser

Overview:
- Serial-to-parallel receive stage directly upstream of hamming74_decoder.
- Collects a serial bit stream into 7-bit Hamming(7,4) codewords, aligned to a start-of-frame marker.
- Presents each codeword on a valid/ready interface whose code_out feeds the decoder's code_in.
- Single-entry holding register, so the next codeword can shift in while the previous one waits; the serial side has no backpressure, so an overflow is flagged and the new codeword is dropped.

Parameters:
- CW_WIDTH, 7: codeword width in bits.
- MSB_FIRST, 1: 1 = first received bit lands in code_out[CW_WIDTH-1]; 0 = first bit lands in code_out[0].
- REQUIRE_SOF, 1: 1 = bits are ignored until the first sof after reset; 0 = start shifting immediately after reset.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is valid this cycle.
- sof  input  1  qualified by bit_valid; marks bit_in as the first bit of a codeword.
- clr_ovf  input  1  clears the overflow flag.
- code_out  output  CW_WIDTH  assembled codeword, to the decoder's code_in.
- code_valid  output  1  code_out holds an unconsumed codeword.
- code_ready  input  1  consumer accepts code_out this cycle.
- overflow  output  1  sticky: a completed codeword was dropped.
- cw_count  output  16  codewords delivered (optional feature).
- drop_count  output  16  codewords dropped (optional feature).

Behaviour:
- Reset (clk edge with rst=1):
  - code_out=0, code_valid=0, overflow=0, cw_count=0, drop_count=0.
  - Shift register and bit counter cleared.
  - State = HUNT if REQUIRE_SOF=1, else SHIFT.
- States:
  - HUNT: bit_valid without sof is ignored. bit_valid with sof stores the bit as bit 0 of the codeword, sets cnt=1 and moves to SHIFT.
  - SHIFT: each bit_valid stores bit_in and increments cnt.
    - When the bit that makes cnt reach CW_WIDTH is accepted, the codeword is complete. It goes to the holding stage and cnt returns to 0 in the same cycle.
    - The state stays SHIFT, so back-to-back codewords need no new sof.
- sof in SHIFT with cnt!=0: the partial codeword is discarded silently (no overflow, no count). bit_in becomes bit 0 of the new codeword and cnt=1.
- sof with bit_valid=0 is ignored.
- Holding stage:
  - A codeword completed in cycle N gives code_valid=1 with the new code_out from cycle N+1. Latency is 1 clock after the last bit.
  - Transfer occurs when code_valid && code_ready. Without a new load, code_valid drops on the next cycle.
  - A completed codeword loads if code_valid=0, or if a transfer happens in the same cycle. A simultaneous drain and load keeps code_valid=1 with the new data.
  - If code_valid=1 and code_ready=0 at completion:
    - The new codeword is dropped and the held codeword is unchanged.
    - overflow is set the next cycle and drop_count increments.
  - code_out and code_valid are stable while code_valid=1 and code_ready=0.
- overflow:
  - Set by a drop; cleared by clr_ovf.
  - If a drop and clr_ovf occur in the same cycle, the set wins.
- Counters: 16-bit, wrap from 0xFFFF to 0. cw_count increments once per transfer.
- Assembled codeword bit order: first bit at index CW_WIDTH-1 when MSB_FIRST=1, at index 0 otherwise.
- rst asserted mid-codeword or mid-handshake: the partial codeword and held codeword are lost. Outputs take their reset values on that edge.

Optional Feature:
- Macro: HAMMING_DESER_STATS_EN.
- Defined: cw_count and drop_count are implemented as described above.
- Undefined: both ports still exist and are tied to 0, and no counter flops are built. overflow and all other behaviour are identical in both builds.

Decomposition:
- Shared package hamming_pkg:
  - Constants HAM_CW_WIDTH=7 and HAM_DATA_WIDTH=4.
  - Typedef ham_cw_t (logic [6:0]).
  - Typedef ham_data_t (logic [3:0]).
  - Typedef for the deser state enum {HUNT, SHIFT}.
- Sub-module: hamming_cw_holdreg.
  - Single-entry valid/ready holding register.
  - Accepts a load strobe and reports a drop.
  - Owns code_out, code_valid and the drop indication.
- The top level owns the state machine, bit counter, shift register, overflow flag and the optional counters.

Test Plan:
- Defaults, code_ready=1; sof with the first bit, stream 1,0,1,0,1,0,1 → code_valid=1 one cycle after the 7th bit, code_out=7'b1010101, cw_count=1.
- REQUIRE_SOF=1; send 3 bits without sof, then sof + 1,1,0,0,1,1,0 → the first 3 bits are ignored and exactly one codeword 7'b1100110 is delivered.
- code_ready=0; send two back-to-back codewords 7'b0000001 then 7'b1111111 → code_out stays 7'b0000001, overflow=1, drop_count=1. Pulse clr_ovf → overflow=0.
- Send 4 bits, then sof + 7 bits of 7'b0110011 → the partial codeword is discarded, only 7'b0110011 is delivered, overflow=0.
- code_ready=1; codeword 7'b1011010 then 7'b0100101 back-to-back → two consecutive transfers, the second code_valid asserted in the cycle after its 7th bit. Feed code_out to hamming74_decoder → error_detected=0 when the stream is a valid encoder output.
- Assert rst after the 4th bit and while code_valid=1 → code_valid=0, code_out=0, overflow=0, counters=0, state HUNT; the next sof-aligned codeword is delivered normally.
